// File: rtl/pipeline_control_pkg.sv
// Shared encodings for the MIPS pipeline control unit: opcodes, ALU codes,
// control-bundle field offsets, bubble values and the MUL hold state type.
package pipeline_control_pkg;

  localparam int ALU_CODE_W = 3;

  // Opcodes of the instruction sitting in ID
  localparam logic [5:0] add_op  = 6'h20;
  localparam logic [5:0] sub_op  = 6'h22;
  localparam logic [5:0] mul_op  = 6'h1C;
  localparam logic [5:0] and_op  = 6'h24;
  localparam logic [5:0] or_op   = 6'h25;
  localparam logic [5:0] addi_op = 6'h08;
  localparam logic [5:0] lw_op   = 6'h23;
  localparam logic [5:0] sw_op   = 6'h2B;
  localparam logic [5:0] beq_op  = 6'h04;
  localparam logic [5:0] j_op    = 6'h02;

  // ALU operation codes; zero is reserved so a bubble never looks like ADD
  localparam logic [ALU_CODE_W-1:0] add_alu = 3'd1;
  localparam logic [ALU_CODE_W-1:0] sub_alu = 3'd2;
  localparam logic [ALU_CODE_W-1:0] mul_alu = 3'd3;
  localparam logic [ALU_CODE_W-1:0] and_alu = 3'd4;
  localparam logic [ALU_CODE_W-1:0] or_alu  = 3'd5;

  // Bundle field offsets: ex {ALUop, ALUsrc, RegDst}, mem {MEM_cs, MEM_we},
  // wb {Reg_we, MemToReg}
  localparam int EX_REGDST_BIT   = 0;
  localparam int EX_ALUSRC_BIT   = 1;
  localparam int EX_ALUOP_LSB    = 2;
  localparam int MEM_WE_BIT      = 0;
  localparam int MEM_CS_BIT      = 1;
  localparam int WB_MEMTOREG_BIT = 0;
  localparam int WB_REGWE_BIT    = 1;

  localparam logic [1:0] mem_bubble = 2'b00;
  localparam logic [1:0] wb_bubble  = 2'b00;

  typedef enum logic {
    RUN      = 1'b0,
    MUL_HOLD = 1'b1
  } mul_state_e;

  function automatic logic is_load(input logic [1:0] mem_ctrl);
    return mem_ctrl[MEM_CS_BIT] & ~mem_ctrl[MEM_WE_BIT];
  endfunction

endpackage

// File: rtl/pipeline_control_if.sv
// ID-stage instruction fields in, stall/redirect controls and the
// per-stage control bundles out.
interface pipeline_control_if #(
  parameter int ALUOP_W    = 3,
  parameter int REG_ADDR_W = 5
);
  logic [5:0]            op_i;
  logic                  is_equal_i;
  logic [REG_ADDR_W-1:0] id_rs_i;
  logic [REG_ADDR_W-1:0] id_rt_i;
  logic                  pc_write_o;
  logic                  ifid_write_o;
  logic                  ifid_flush_o;
  logic                  jump_o;
  logic                  branch_o;
  logic [ALUOP_W+1:0]    ex_ctrl_o;
  logic [1:0]            mem_ctrl_o;
  logic [1:0]            wb_ctrl_o;
  logic                  mul_busy_o;

  modport master (
    output op_i, is_equal_i, id_rs_i, id_rt_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, jump_o, branch_o,
           ex_ctrl_o, mem_ctrl_o, wb_ctrl_o, mul_busy_o
  );

  modport slave (
    input  op_i, is_equal_i, id_rs_i, id_rt_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, jump_o, branch_o,
           ex_ctrl_o, mem_ctrl_o, wb_ctrl_o, mul_busy_o
  );
endinterface

// File: rtl/pipeline_control_decoder.sv
// Pure combinational opcode decode into the EX/MEM/WB control bundles.
// Anything not recognised (including J and BEQ) decodes to an all-zero bubble.
module control_decoder
  import pipeline_control_pkg::*;
#(
  parameter int ALUOP_W = 3
) (
  input  logic [5:0]         op,
  output logic [ALUOP_W+1:0] ex_ctrl,
  output logic [1:0]         mem_ctrl,
  output logic [1:0]         wb_ctrl,
  output logic               is_mul
);

  // Bundle lookup; defaults give the bubble
  always_comb begin
    ex_ctrl  = '0;
    mem_ctrl = mem_bubble;
    wb_ctrl  = wb_bubble;
    is_mul   = 1'b0;
    case (op)
      add_op, sub_op, mul_op, and_op, or_op: begin
        ex_ctrl[EX_REGDST_BIT]  = 1'b1;
        wb_ctrl[WB_REGWE_BIT]   = 1'b1;
        case (op)
          sub_op:  ex_ctrl[EX_ALUOP_LSB +: ALUOP_W] = ALUOP_W'(sub_alu);
          mul_op:  ex_ctrl[EX_ALUOP_LSB +: ALUOP_W] = ALUOP_W'(mul_alu);
          and_op:  ex_ctrl[EX_ALUOP_LSB +: ALUOP_W] = ALUOP_W'(and_alu);
          or_op:   ex_ctrl[EX_ALUOP_LSB +: ALUOP_W] = ALUOP_W'(or_alu);
          default: ex_ctrl[EX_ALUOP_LSB +: ALUOP_W] = ALUOP_W'(add_alu);
        endcase
        is_mul = (op == mul_op);
      end
      addi_op: begin
        ex_ctrl[EX_ALUOP_LSB +: ALUOP_W] = ALUOP_W'(add_alu);
        ex_ctrl[EX_ALUSRC_BIT]           = 1'b1;
        wb_ctrl[WB_REGWE_BIT]            = 1'b1;
      end
      lw_op: begin
        ex_ctrl[EX_ALUOP_LSB +: ALUOP_W] = ALUOP_W'(add_alu);
        ex_ctrl[EX_ALUSRC_BIT]           = 1'b1;
        mem_ctrl[MEM_CS_BIT]             = 1'b1;
        wb_ctrl[WB_REGWE_BIT]            = 1'b1;
        wb_ctrl[WB_MEMTOREG_BIT]         = 1'b1;
      end
      sw_op: begin
        ex_ctrl[EX_ALUOP_LSB +: ALUOP_W] = ALUOP_W'(add_alu);
        ex_ctrl[EX_ALUSRC_BIT]           = 1'b1;
        mem_ctrl[MEM_CS_BIT]             = 1'b1;
        mem_ctrl[MEM_WE_BIT]             = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipeline_control.sv
// Pipeline control unit: ID decode, ID/EX -> EX/MEM -> MEM/WB control
// registers, load-use stall, multi-cycle MUL hold and ID-stage BEQ/J redirect.
//
// state    | meaning
// RUN      | pipeline advancing normally
// MUL_HOLD | MUL in EX: ID/EX frozen, bubbles into EX/MEM, PC/IF-ID stalled
//
// The MUL is entered into MUL_HOLD on the edge that loads it into ID/EX and
// stays there MUL_LATENCY-1 cycles; it then spends one ordinary RUN cycle in
// EX and moves into EX/MEM on the following edge, so it occupies EX for
// MUL_LATENCY cycles in total.
module pipeline_control
  import pipeline_control_pkg::*;
#(
  parameter int ALUOP_W     = 3,
  parameter int REG_ADDR_W  = 5,
  parameter int MUL_LATENCY = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  pipeline_control_if.slave  bus
);

  localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

  logic [ALUOP_W+1:0]    dec_ex;
  logic [1:0]            dec_mem;
  logic [1:0]            dec_wb;
  logic                  dec_is_mul;

  logic [ALUOP_W+1:0]    idex_ex;
  logic [1:0]            idex_mem;
  logic [1:0]            idex_wb;
  logic [REG_ADDR_W-1:0] idex_rt;
  logic [1:0]            exmem_mem;
  logic [1:0]            exmem_wb;
  logic [1:0]            memwb_wb;

  mul_state_e            state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;

  logic                  mul_hold;
  logic                  load_stall;
  logic                  stall;
  logic                  jump;
  logic                  branch;

  control_decoder #(.ALUOP_W(ALUOP_W)) u_decoder (
    .op       (bus.op_i),
    .ex_ctrl  (dec_ex),
    .mem_ctrl (dec_mem),
    .wb_ctrl  (dec_wb),
    .is_mul   (dec_is_mul)
  );

  // Hazard detection and ID-stage redirect; any stall suppresses the redirect
  always_comb begin
    mul_hold   = (state == MUL_HOLD);
    load_stall = !mul_hold && is_load(idex_mem) && (idex_rt != '0) &&
                 ((idex_rt == bus.id_rs_i) || (idex_rt == bus.id_rt_i));
    stall      = mul_hold || load_stall;
    jump       = 1'b0;
    branch     = 1'b0;
    if (!stall) begin
      jump   = (bus.op_i == j_op);
      branch = (bus.op_i == beq_op) && bus.is_equal_i;
    end
  end

  assign bus.pc_write_o   = !stall;
  assign bus.ifid_write_o = !stall;
  assign bus.jump_o       = jump;
  assign bus.branch_o     = branch;
  assign bus.ifid_flush_o = jump || branch;
  assign bus.mul_busy_o   = mul_hold;
  assign bus.ex_ctrl_o    = idex_ex;
  assign bus.mem_ctrl_o   = exmem_mem;
  assign bus.wb_ctrl_o    = memwb_wb;

  // MUL hold next-state: down-counter with terminal count at 1
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        if (!stall && dec_is_mul && (MUL_LATENCY > 1)) begin
          state_nxt = MUL_HOLD;
          cnt_nxt   = CNT_W'(MUL_LATENCY - 1);
        end
      end
      MUL_HOLD: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // MUL hold state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Control pipeline registers: ID/EX freezes under MUL hold and takes a
  // bubble on a load-use stall; EX/MEM takes bubbles while the MUL is held
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idex_ex   <= '0;
      idex_mem  <= mem_bubble;
      idex_wb   <= wb_bubble;
      idex_rt   <= '0;
      exmem_mem <= mem_bubble;
      exmem_wb  <= wb_bubble;
      memwb_wb  <= wb_bubble;
    end else begin
      memwb_wb <= exmem_wb;
      if (mul_hold) begin
        exmem_mem <= mem_bubble;
        exmem_wb  <= wb_bubble;
      end else begin
        exmem_mem <= idex_mem;
        exmem_wb  <= idex_wb;
        if (load_stall) begin
          idex_ex  <= '0;
          idex_mem <= mem_bubble;
          idex_wb  <= wb_bubble;
          idex_rt  <= '0;
        end else begin
          idex_ex  <= dec_ex;
          idex_mem <= dec_mem;
          idex_wb  <= dec_wb;
          idex_rt  <= bus.id_rt_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipeline_control.sv
// Bench for pipeline_control: an instruction-level reference model tracks
// which instruction occupies each stage; the driver pushes the expected
// output vector per cycle and a separate monitor pops and compares it.
module tb_pipeline_control;
  localparam int ALUOP_W     = 3;
  localparam int REG_ADDR_W  = 5;
  localparam int MUL_LATENCY = 3;

  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_ADD  = 6'h20;
  localparam logic [5:0] OP_SUB  = 6'h22;
  localparam logic [5:0] OP_MUL  = 6'h1C;
  localparam logic [5:0] OP_AND  = 6'h24;
  localparam logic [5:0] OP_OR   = 6'h25;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BAD  = 6'h3F;

  typedef logic [14:0] obs_t;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  pipeline_control_if #(.ALUOP_W(ALUOP_W), .REG_ADDR_W(REG_ADDR_W)) bus ();

  pipeline_control #(
    .ALUOP_W(ALUOP_W), .REG_ADDR_W(REG_ADDR_W), .MUL_LATENCY(MUL_LATENCY)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  logic [5:0] cur_op;
  logic [4:0] cur_rs, cur_rt;
  logic       cur_eq;

  // Reference model: opcode occupying each stage, plus remaining hold cycles
  logic [5:0] m_ex_op, m_exmem_op, m_memwb_op;
  logic [4:0] m_ex_rt;
  int         m_ex_left;

  logic [5:0] op_pool [0:11];

  function automatic logic [4:0] ex_of(input logic [5:0] op);
    case (op)
      OP_ADD:               return {3'd1, 1'b0, 1'b1};
      OP_SUB:               return {3'd2, 1'b0, 1'b1};
      OP_MUL:               return {3'd3, 1'b0, 1'b1};
      OP_AND:               return {3'd4, 1'b0, 1'b1};
      OP_OR:                return {3'd5, 1'b0, 1'b1};
      OP_ADDI, OP_LW, OP_SW: return {3'd1, 1'b1, 1'b0};
      default:              return 5'b0;
    endcase
  endfunction

  function automatic logic [1:0] mem_of(input logic [5:0] op);
    if (op == OP_LW) return 2'b10;
    if (op == OP_SW) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [1:0] wb_of(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_ADDI: return 2'b10;
      OP_LW:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic hold_now();
    return m_ex_left > 0;
  endfunction

  function automatic logic ldst_now();
    return !hold_now() && (m_ex_op == OP_LW) && (m_ex_rt != 5'd0) &&
           ((m_ex_rt == cur_rs) || (m_ex_rt == cur_rt));
  endfunction

  function automatic obs_t expect_now();
    logic st, jmp, br;
    st  = hold_now() || ldst_now();
    jmp = !st && (cur_op == OP_J);
    br  = !st && (cur_op == OP_BEQ) && cur_eq;
    return {!st, !st, jmp | br, jmp, br, hold_now(),
            ex_of(m_ex_op), mem_of(m_exmem_op), wb_of(m_memwb_op)};
  endfunction

  task automatic model_clear();
    m_ex_op = OP_NOP; m_exmem_op = OP_NOP; m_memwb_op = OP_NOP;
    m_ex_rt = 5'd0;   m_ex_left  = 0;
  endtask

  task automatic model_advance();
    logic h, l;
    h = hold_now();
    l = ldst_now();
    m_memwb_op = m_exmem_op;
    m_exmem_op = h ? OP_NOP : m_ex_op;
    if (h) m_ex_left = m_ex_left - 1;
    else if (l) begin
      m_ex_op = OP_NOP;
      m_ex_rt = 5'd0;
    end else begin
      m_ex_op   = cur_op;
      m_ex_rt   = cur_rt;
      m_ex_left = (cur_op == OP_MUL) ? MUL_LATENCY - 1 : 0;
    end
  endtask

  task automatic set_in(input logic [5:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic eq);
    cur_op = op; cur_rs = rs; cur_rt = rt; cur_eq = eq;
    bus.op_i = op; bus.id_rs_i = rs; bus.id_rt_i = rt; bus.is_equal_i = eq;
  endtask

  // One clock: publish this cycle's expectation, then step the model on the edge
  task automatic cycle(output logic st);
    exp_q.push_back(expect_now());
    st = hold_now() || ldst_now();
    @(posedge clk_i);
    if (!rst_i) model_advance();
    #1;
  endtask

  task automatic issue(input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic eq);
    logic st;
    int   guard;
    set_in(op, rs, rt, eq);
    cycle(st);
    guard = 0;
    while (st && guard < 10) begin
      cycle(st);
      guard++;
    end
    if (st) begin
      n_checks++;
      $display("FAIL issue_timeout op=%h still stalled after %0d cycles, required accepted", op, guard);
    end
  endtask

  task automatic do_reset(input int n);
    logic st;
    rst_i = 1'b1;
    model_clear();
    repeat (n) cycle(st);
    rst_i = 1'b0;
  endtask

  // Monitor: pops one expectation per cycle, mid-cycle
  initial begin
    obs_t e, g;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {bus.pc_write_o, bus.ifid_write_o, bus.ifid_flush_o, bus.jump_o,
             bus.branch_o, bus.mul_busy_o, bus.ex_ctrl_o, bus.mem_ctrl_o,
             bus.wb_ctrl_o};
        n_checks++;
        if (g === e) n_pass++;
        else $display("FAIL outputs cycle %0d got=%b required=%b (pc,ifid,flush,j,br,busy,ex,mem,wb)",
                      cyc, g, e);
      end
    end
  end

  initial begin
    op_pool[0] = OP_ADD;  op_pool[1]  = OP_SUB; op_pool[2]  = OP_MUL;
    op_pool[3] = OP_AND;  op_pool[4]  = OP_OR;  op_pool[5]  = OP_ADDI;
    op_pool[6] = OP_LW;   op_pool[7]  = OP_SW;  op_pool[8]  = OP_BEQ;
    op_pool[9] = OP_J;    op_pool[10] = OP_LW;  op_pool[11] = OP_BAD;

    rst_i = 1'b1;
    set_in(OP_NOP, 5'd0, 5'd0, 1'b0);
    model_clear();
    @(posedge clk_i);
    #1;
    do_reset(2);

    // ADD, SUB, then a MUL interrupted by reset during its hold
    issue(OP_ADD, 5'd1, 5'd2, 1'b0);
    issue(OP_SUB, 5'd3, 5'd4, 1'b0);
    issue(OP_MUL, 5'd1, 5'd2, 1'b0);
    begin
      logic st;
      set_in(OP_ADD, 5'd5, 5'd6, 1'b0);
      cycle(st);
    end
    do_reset(2);
    issue(OP_ADD, 5'd5, 5'd6, 1'b0);

    // Load-use, rt=0 and independent cases
    issue(OP_LW,  5'd0, 5'd5, 1'b0);
    issue(OP_ADD, 5'd5, 5'd1, 1'b0);
    issue(OP_LW,  5'd0, 5'd0, 1'b0);
    issue(OP_ADD, 5'd0, 5'd0, 1'b0);
    issue(OP_LW,  5'd0, 5'd5, 1'b0);
    issue(OP_ADD, 5'd6, 5'd7, 1'b0);

    // MUL hold, back-to-back MUL
    issue(OP_MUL, 5'd1, 5'd2, 1'b0);
    issue(OP_ADD, 5'd3, 5'd4, 1'b0);
    issue(OP_MUL, 5'd1, 5'd2, 1'b0);
    issue(OP_MUL, 5'd2, 5'd3, 1'b0);
    issue(OP_ADD, 5'd1, 5'd1, 1'b0);

    // BEQ taken / not taken / behind a load-use stall, unknown opcode, J
    issue(OP_BEQ, 5'd1, 5'd2, 1'b1);
    issue(OP_BEQ, 5'd1, 5'd2, 1'b0);
    issue(OP_LW,  5'd0, 5'd5, 1'b0);
    issue(OP_BEQ, 5'd5, 5'd1, 1'b1);
    issue(OP_BAD, 5'd0, 5'd0, 1'b0);
    issue(OP_J,   5'd0, 5'd0, 1'b0);
    issue(OP_NOP, 5'd0, 5'd0, 1'b0);

    // Randomized traffic with small register numbers to provoke hazards
    for (int i = 0; i < 600; i++) begin
      issue(op_pool[$urandom_range(0, 11)],
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 6; i++) issue(OP_NOP, 5'd0, 5'd0, 1'b0);

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk_i);
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain %0d expectations left, required 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
